// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: FSM encoding, ALU idle
// drive values and the select codes callers use.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [3:0] ALU_IDLE_S  = 4'b0000;
   localparam logic       ALU_IDLE_M  = 1'b1;
   localparam logic       ALU_IDLE_CN = 1'b0;

   localparam logic [3:0] SEL_ADD = 4'b1001;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_XOR = 4'b0110;  // same code as SUB, taken with M=1

endpackage

// File: rtl/alu_seq_ctrl.sv
// Drives a W-bit operation through an external 8-bit ALU one byte per cycle.
// Optional feature: define ALU_SEQ_ZERO_EN to register a result-is-zero flag.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int BYTES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_s,
   input  logic              req_m,
   input  logic              req_cn,
   input  logic [8*BYTES-1:0] req_a,
   input  logic [8*BYTES-1:0] req_b,
   output logic [3:0]        alu_s,
   output logic              alu_m,
   output logic              alu_cn,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   input  logic [7:0]        alu_f,
   input  logic              alu_co,
   input  logic              alu_fz,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [8*BYTES-1:0] rsp_f,
   output logic              rsp_co,
   output logic              rsp_ne,
   output logic              rsp_z
);

   localparam int W  = 8 * BYTES;
   localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [3:0]      s_q, s_d;
   logic            m_q, m_d;
   logic            cn_q, cn_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    f_q, f_d;
   logic            co_q, co_d;
   logic            ne_q, ne_d;
`ifdef ALU_SEQ_ZERO_EN
   logic            z_q, z_d;
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      s_d     = s_q;
      m_d     = m_q;
      cn_d    = cn_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      f_d     = f_q;
      co_d    = co_q;
      ne_d    = ne_q;
`ifdef ALU_SEQ_ZERO_EN
      z_d     = z_q;
`endif
      alu_s   = ALU_IDLE_S;
      alu_m   = ALU_IDLE_M;
      alu_cn  = ALU_IDLE_CN;
      alu_a   = 8'h00;
      alu_b   = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               s_d     = req_s;
               m_d     = req_m;
               cn_d    = req_cn;
               a_d     = req_a;
               b_d     = req_b;
               k_d     = '0;
               ne_d    = 1'b0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_s  = s_q;
            alu_m  = m_q;
            // Byte 0 and logic ops take the caller's carry; higher arithmetic bytes chain.
            alu_cn = (k_q == '0 || m_q) ? cn_q : carry_q;
            alu_a  = a_q[8*k_q +: 8];
            alu_b  = b_q[8*k_q +: 8];
            f_d[8*k_q +: 8] = alu_f;
            carry_d = alu_co;
            ne_d    = ne_q | alu_fz;
            k_d     = k_q + KW'(1);
            if (k_q == KW'(BYTES - 1)) begin
               k_d     = '0;
               co_d    = m_q ? 1'b0 : alu_co;
`ifdef ALU_SEQ_ZERO_EN
               z_d     = (f_d == '0);
`endif
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         s_q     <= '0;
         m_q     <= 1'b0;
         cn_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         f_q     <= '0;
         co_q    <= 1'b0;
         ne_q    <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
         z_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         s_q     <= s_d;
         m_q     <= m_d;
         cn_q    <= cn_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         f_q     <= f_d;
         co_q    <= co_d;
         ne_q    <= ne_d;
`ifdef ALU_SEQ_ZERO_EN
         z_q     <= z_d;
`endif
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_f     = f_q;
   assign rsp_co    = co_q;
   assign rsp_ne    = ne_q;
`ifdef ALU_SEQ_ZERO_EN
   assign rsp_z     = z_q;
`else
   assign rsp_z     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl (BYTES=2) with a behavioural 8-bit ALU; results are
// compared against whole-word arithmetic.
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   localparam int BYTES = 2;
   localparam int W     = 8 * BYTES;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_m, req_cn;
   logic [3:0]   req_s;
   logic [W-1:0] req_a, req_b;
   logic [3:0]   alu_s;
   logic         alu_m, alu_cn, alu_co, alu_fz;
   logic [7:0]   alu_a, alu_b, alu_f;
   logic         rsp_valid, rsp_ready, rsp_co, rsp_ne, rsp_z;
   logic [W-1:0] rsp_f;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.BYTES(BYTES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_s(req_s), .req_m(req_m), .req_cn(req_cn), .req_a(req_a), .req_b(req_b),
      .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn), .alu_a(alu_a), .alu_b(alu_b),
      .alu_f(alu_f), .alu_co(alu_co), .alu_fz(alu_fz),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_f(rsp_f), .rsp_co(rsp_co), .rsp_ne(rsp_ne), .rsp_z(rsp_z)
   );

   // 8-bit ALU: add with carry, subtract with borrow, logic XOR.
   always_comb begin
      logic [8:0] t;
      t      = 9'd0;
      alu_f  = 8'h00;
      alu_co = 1'b0;
      if (!alu_m && alu_s == SEL_ADD) begin
         t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cn};
         alu_f = t[7:0]; alu_co = t[8];
      end else if (!alu_m && alu_s == SEL_SUB) begin
         t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cn};
         alu_f = t[7:0]; alu_co = t[8];
      end else if (alu_m && alu_s == SEL_XOR) begin
         alu_f = alu_a ^ alu_b;
      end
      alu_fz = (alu_a != alu_b);
   end

   // Whole-word reference model.
   task automatic model(input logic [3:0] s, input logic m, input logic cn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] f, output logic co,
                        output logic ne, output logic z);
      logic [W:0] t;
      t = '0;
      f = '0; co = 1'b0;
      if (!m && s == SEL_ADD) begin
         t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cn};
         f = t[W-1:0]; co = t[W];
      end else if (!m && s == SEL_SUB) begin
         t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cn};
         f = t[W-1:0]; co = t[W];
      end else if (m && s == SEL_XOR) begin
         f = a ^ b;
      end
      ne = (a != b);
`ifdef ALU_SEQ_ZERO_EN
      z = (f == '0);
`else
      z = 1'b0;
`endif
   endtask

   // Issues one request and waits for the response; lat = -1 on timeout.
   task automatic do_op(input logic [3:0] s, input logic m, input logic cn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] f, output logic co,
                        output logic ne, output logic z, output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_s = s; req_m = m; req_cn = cn; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
      if (!rsp_valid) lat = -1;
      f = rsp_f; co = rsp_co; ne = rsp_ne; z = rsp_z;
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_f !== '0 || rsp_co !== 1'b0 ||
          rsp_ne !== 1'b0 || rsp_z !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp: rdy=%b vld=%b f=%h co=%b ne=%b z=%b, required 1 0 0000 0 0 0",
                  req_ready, rsp_valid, rsp_f, rsp_co, rsp_ne, rsp_z);
      end
      checks++;
      if (alu_s !== 4'b0000 || alu_m !== 1'b1 || alu_cn !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
         errors++;
         $display("FAIL reset_alu: s=%b m=%b cn=%b a=%h b=%h, required 0000 1 0 00 00",
                  alu_s, alu_m, alu_cn, alu_a, alu_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [3:0]   s  [7];
      logic         m  [7];
      logic [W-1:0] a  [7];
      logic [W-1:0] b  [7];
      logic [W-1:0] ef [7];
      logic         eco[7];
      logic [W-1:0] f, mf;
      logic co, ne, z, mco, mne, mz;
      int lat;
      s = '{SEL_ADD, SEL_ADD, SEL_SUB, SEL_SUB, SEL_XOR, SEL_XOR, SEL_ADD};
      m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      a = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h0100, 16'h1234, 16'h5A5A, 16'h1234};
      b = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h00FF, 16'h5A5A, 16'h1234};
      ef  = '{16'h0100, 16'h0000, 16'hFFFF, 16'h00FF, 16'h12CB, 16'h0000, 16'h2468};
      eco = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         do_op(s[i], m[i], 1'b0, a[i], b[i], 0, f, co, ne, z, lat);
         model(s[i], m[i], 1'b0, a[i], b[i], mf, mco, mne, mz);
         checks++;
         if (lat !== 2) begin
            errors++; $display("FAIL dir%0d_latency: got %0d, required 2", i, lat);
         end
         checks++;
         if (f !== ef[i] || co !== eco[i]) begin
            errors++; $display("FAIL dir%0d_result: f=%h co=%b, required f=%h co=%b", i, f, co, ef[i], eco[i]);
         end
         checks++;
         if (ne !== mne || z !== mz) begin
            errors++; $display("FAIL dir%0d_flags: ne=%b z=%b, required ne=%b z=%b", i, ne, z, mne, mz);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] s;
      logic m, cn, co, ne, z, mco, mne, mz;
      logic [W-1:0] a, b, f, mf;
      int lat, op;
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 2));
         s  = (op == 0) ? SEL_ADD : ((op == 1) ? SEL_SUB : SEL_XOR);
         m  = (op == 2);
         cn = 1'($urandom);
         a  = W'($urandom);
         b  = (i % 8 == 0) ? a : W'($urandom);
         do_op(s, m, cn, a, b, int'($urandom_range(0, 2)), f, co, ne, z, lat);
         model(s, m, cn, a, b, mf, mco, mne, mz);
         checks++;
         if (lat !== 2 || f !== mf || co !== mco || ne !== mne || z !== mz) begin
            errors++;
            $display("FAIL rand%0d op=%0d cn=%b a=%h b=%h: lat=%0d f=%h co=%b ne=%b z=%b, required lat=2 f=%h co=%b ne=%b z=%b",
                     i, op, cn, a, b, lat, f, co, ne, z, mf, mco, mne, mz);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] f0;
      int n;
      @(negedge clk);
      req_s = SEL_ADD; req_m = 1'b0; req_cn = 1'b1; req_a = 16'h7F80; req_b = 16'h0080;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Keep requesting while busy: must be held off, then taken after the response.
      n = 0;
      while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: rsp_valid never rose"); end
      f0 = rsp_f;
      checks++;
      if (f0 !== 16'h8001) begin errors++; $display("FAIL bp_result: f=%h, required 8001", f0); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_f !== f0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: vld=%b f=%h rdy=%b, required 1 %h 0", c, rsp_valid, rsp_f, req_ready, f0);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_rdy: got %b, required 0", req_ready); end
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
      end
      // Held request is accepted now and completes with the same operands.
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_f !== 16'h8001 || rsp_co !== 1'b0) begin
         errors++; $display("FAIL bp_held_req: vld=%b f=%h co=%b, required 1 8001 0", rsp_valid, rsp_f, rsp_co);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk);
      req_s = SEL_ADD; req_m = 1'b0; req_cn = 1'b0; req_a = 16'hABCD; req_b = 16'h1111;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (alu_s !== SEL_ADD || alu_m !== 1'b0 || alu_a !== 8'hCD || alu_b !== 8'h11) begin
         errors++; $display("FAIL mid_exec_drive: s=%b m=%b a=%h b=%h, required 1001 0 cd 11", alu_s, alu_m, alu_a, alu_b);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_f !== '0 || rsp_co !== 1'b0 ||
          rsp_ne !== 1'b0 || rsp_z !== 1'b0 || alu_m !== 1'b1 || alu_a !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_state: rdy=%b vld=%b f=%h co=%b ne=%b z=%b alu_m=%b alu_a=%h, required 1 0 0000 0 0 0 1 00",
                  req_ready, rsp_valid, rsp_f, rsp_co, rsp_ne, rsp_z, alu_m, alu_a);
      end
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL mid_no_rsp: %0d rsp_valid cycles, required 0", pulses); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_s = '0; req_m = 1'b0; req_cn = 1'b0; req_a = '0; req_b = '0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: BYTES, default 2, operand width in bytes (legal 1..4; W = 8*BYTES).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_s  in  4  ALU function select.
REQ-008 req_m  in  1  mode: 0 = arithmetic, 1 = logic.
REQ-009 req_cn  in  1  initial carry or borrow.
REQ-010 req_a, req_b  in  W  operands.
REQ-011 alu_s  out  4  select driven to the 8-bit ALU.
REQ-012 alu_m, alu_cn  out  1 each  mode and carry driven to the ALU.
REQ-013 alu_a, alu_b  out  8 each  operand byte driven to the ALU.
REQ-014 alu_f  in  8  ALU result byte.
REQ-015 alu_co  in  1  ALU carry or borrow out.
REQ-016 alu_fz  in  1  ALU inequality flag (1 = bytes differ).
REQ-017 rsp_valid  out  1  result available.
REQ-018 rsp_ready  in  1  consumer accepts the result.
REQ-019 rsp_f  out  W  result.
REQ-020 rsp_co  out  1  final carry or borrow.
REQ-021 rsp_ne  out  1  operands differ.
REQ-022 rsp_z  out  1  result is zero.

Function
REQ-023 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-024 In IDLE, req_ready SHALL be 1.
REQ-025 When req_valid and req_ready are both 1, the block SHALL register S, M, CN, A and B, clear the byte index k to 0, clear rsp_ne, and go to EXEC.
REQ-026 In EXEC, the block SHALL drive the stored S and M, plus A[8k+7:8k] and B[8k+7:8k], to the ALU.
REQ-027 In EXEC, alu_cn SHALL be: stored CN when k=0; carry register when k>0 and M=0; stored CN when M=1.
REQ-028 On each EXEC clock edge, the block SHALL write alu_f into rsp_f byte k, load alu_co into the carry register, OR alu_fz into rsp_ne, and increment k.
REQ-029 After the byte k=BYTES-1, the FSM SHALL go to RESP; total latency is BYTES EXEC cycles after acceptance.
REQ-030 In RESP, rsp_valid SHALL be 1, and rsp_f, rsp_co, rsp_ne and rsp_z SHALL be held stable until rsp_ready=1.
REQ-031 When rsp_valid and rsp_ready are both 1, the FSM SHALL go to IDLE; req_ready SHALL be 0 in that same cycle, so there is no same-cycle re-accept.
REQ-032 rsp_co SHALL equal the carry of the last byte when M=0, and 0 when M=1.
REQ-033 Carry chaining SHALL be uniform: for add-type selects the chained bit is a carry, and for subtract-type selects (e.g. S=0110) it is a borrow.
REQ-034 Outside EXEC, the ALU outputs SHALL be alu_s=0000, alu_m=1, alu_cn=0, alu_a=0, alu_b=0.
REQ-035 ALU-side outputs SHALL depend only on registered state; there is no combinational path from req_* inputs.
REQ-036 req_valid asserted while not in IDLE SHALL be ignored and not lost; the requester holds it.

Reset
REQ-037 On rst, the block SHALL go to IDLE and set req_ready=1, rsp_valid=0, rsp_f=0, rsp_co=0, rsp_ne=0, rsp_z=0 and k=0.
REQ-038 rst asserted in EXEC or RESP SHALL abort the operation and discard the partial result, with no response issued.
REQ-039 rst SHALL take priority over a simultaneous request or response handshake.

Configuration
REQ-040 With ALU_SEQ_ZERO_EN defined, rsp_z SHALL be registered as (rsp_f == 0), valid whenever rsp_valid=1.
REQ-041 Without ALU_SEQ_ZERO_EN, rsp_z SHALL be a constant 0 and no zero-detect logic SHALL exist.

Structure
REQ-042 A shared package alu_seq_pkg SHALL hold the state encoding (IDLE, EXEC, RESP).
REQ-043 alu_seq_pkg SHALL hold the ALU idle constants: S=0000, M=1, CN=0.
REQ-044 alu_seq_pkg SHALL hold the ALU select codes SEL_ADD=1001, SEL_SUB=0110 and SEL_XOR=0110 (logic mode).
REQ-045 The block SHALL contain no sub-module; the team's 8-bit ALU is instantiated alongside it, in the bench and at CPU top.

Verification (BYTES=2, bench connects the real ALU)
REQ-046 Add without cross-byte overflow: S=1001, M=0, CN=0, A=0x00FF, B=0x0001 -> rsp_f=0x0100, rsp_co=0, rsp_z=0, rsp_valid exactly 2 cycles after accept.
REQ-047 Add with overflow: S=1001, M=0, CN=0, A=0xFFFF, B=0x0001 -> rsp_f=0x0000, rsp_co=1, rsp_z=1 (with ALU_SEQ_ZERO_EN), rsp_ne=1.
REQ-048 Subtract with borrow out: S=0110, M=0, CN=0, A=0x0000, B=0x0001 -> rsp_f=0xFFFF, rsp_co=1; and A=0x0100, B=0x0001 -> rsp_f=0x00FF, rsp_co=0.
REQ-049 Logic XOR: S=0110, M=1, A=0x1234, B=0x00FF -> rsp_f=0x12CB, rsp_co=0; and A=B=0x5A5A -> rsp_ne=0.
REQ-050 Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid and rsp_f stable; req_ready=0 throughout, and req_ready=1 one cycle after rsp_ready=1.
REQ-051 Reset mid-operation: assert rst in the first EXEC cycle -> next cycle IDLE with all outputs at reset values; no rsp_valid pulse.
